// File: rtl/sync_pkt_source_if.sv
// ---------------------------------------------------------------------------
// sync_pkt_source_if
//
// Packet bus between sync_pkt_source and the sync receiver. One beat per
// cycle, no back-pressure: the receiver must consume every beat with
// valid=1.
//
// Signals
//   valid : beat present this cycle
//   addr  : packet address (load / decrement command selector)
//   data  : packet payload (load value; zero for decrement packets)
//
// Modports
//   master : packet producer (sync_pkt_source)
//   slave  : packet consumer (receiver / testbench monitor)
// ---------------------------------------------------------------------------
interface sync_pkt_source_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, addr, data);
  modport slave  (input  valid, addr, data);

endinterface

// File: rtl/sync_pkt_source.sv
// ---------------------------------------------------------------------------
// sync_pkt_source
//
// Issues one command's worth of packets to a remote sync counter: a single
// LOAD packet carrying the count, followed by `count` DEC packets with an
// optional idle gap after each one. It then waits for the receiver to report
// that its counter reached zero (sync), or gives up after TIMEOUT cycles, and
// finishes with a one-cycle done pulse whose err flag tells which happened.
//
// Parameters
//   LOAD_ADDR : packet address that loads the remote counter
//   DEC_ADDR  : packet address that decrements the remote counter
//   TIMEOUT   : max cycles spent waiting for sync after the last packet
//   ADDR_W    : width of pkt_out.addr (must match the interface instance)
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   cmd_valid : command request (held by the requester until accepted)
//   cmd_ready : command accept, high only while idle
//   cmd_count : number of DEC packets to issue
//   cmd_gap   : idle cycles inserted after each DEC packet
//   pkt_out   : packet stream to the sync receiver (master modport)
//   sync      : registered zero-reached flag from the receiver
//   busy      : high whenever a command is in progress
//   done      : one-cycle completion pulse
//   err       : timeout status, valid with done, held until next accept
// ---------------------------------------------------------------------------
module sync_pkt_source #(
  parameter int unsigned LOAD_ADDR = 128,
  parameter int unsigned DEC_ADDR  = 130,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int          ADDR_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [63:0]              cmd_count,
  input  logic [7:0]               cmd_gap,
  sync_pkt_source_if.master        pkt_out,
  input  logic                     sync,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // Counter is wide enough to hold TIMEOUT-1, the value at which we give up.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DEC,
    GAP,
    WAIT_SYNC,
    FIN
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [63:0]   remaining;
  logic [7:0]    gap_len;
  logic [7:0]    gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  logic          accept;
  logic          tmo_hit;

  assign accept  = cmd_valid && cmd_ready;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      gap_len   <= '0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;

      case (state)
        IDLE: begin
          if (accept) begin
            remaining <= cmd_count;
            gap_len   <= cmd_gap;
            err_q     <= 1'b0;
          end
        end

        DEC: begin
          // Guarded so a zero count can never wrap to all-ones.
          if (remaining != 64'd0) begin
            remaining <= remaining - 64'd1;
          end
          // Down-counter: GAP exits on the cycle it reads zero, giving
          // exactly gap_len idle cycles.
          gap_cnt <= gap_len - 8'd1;
        end

        GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        WAIT_SYNC: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          // sync takes priority over a simultaneous timeout.
          if (!sync && tmo_hit) begin
            err_q <= 1'b1;
          end
        end

        default: begin
        end
      endcase

      // Fresh timeout window on every entry into WAIT_SYNC.
      if ((state_next == WAIT_SYNC) && (state != WAIT_SYNC)) begin
        tmo_cnt <= '0;
      end
    end
  end

  // All outputs are forced low while reset is high so that an abort takes
  // effect in the same cycle, independent of the registered state.
  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    pkt_out.valid = 1'b0;
    pkt_out.addr  = '0;
    pkt_out.data  = '0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        state_next = (remaining == 64'd0) ? WAIT_SYNC : DEC;
      end

      DEC: begin
        if (remaining <= 64'd1) begin
          state_next = WAIT_SYNC;
        end else if (gap_len != 8'd0) begin
          state_next = GAP;
        end else begin
          state_next = DEC;
        end
      end

      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_next = DEC;
        end
      end

      WAIT_SYNC: begin
        if (sync || tmo_hit) begin
          state_next = FIN;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (!reset) begin
      cmd_ready = (state == IDLE);
      busy      = (state != IDLE);
      done      = (state == FIN);
      err       = err_q;

      if (state == LOAD) begin
        pkt_out.valid = 1'b1;
        pkt_out.addr  = ADDR_W'(LOAD_ADDR);
        pkt_out.data  = remaining;
      end else if (state == DEC) begin
        pkt_out.valid = 1'b1;
        pkt_out.addr  = ADDR_W'(DEC_ADDR);
        pkt_out.data  = '0;
      end
    end
  end

endmodule

// File: tb/tb_sync_pkt_source.sv
// ---------------------------------------------------------------------------
// tb_sync_pkt_source
//
// Table of directed commands plus a randomized command sequence. For every
// command the bench derives, from the count/gap and the cycle at which it
// raises sync, where each packet must appear, when done must pulse and what
// err must be, then compares all DUT outputs cycle by cycle.
// ---------------------------------------------------------------------------
module tb_sync_pkt_source;

  localparam int TMO       = 16;
  localparam int LOAD_A    = 128;
  localparam int DEC_A     = 130;
  localparam int MAX_CYC   = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_count;
  logic [7:0]  cmd_gap;
  logic        sync;
  logic        busy;
  logic        done;
  logic        err;

  sync_pkt_source_if pkt_if ();

  sync_pkt_source #(
    .LOAD_ADDR (LOAD_A),
    .DEC_ADDR  (DEC_A),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .cmd_gap   (cmd_gap),
    .pkt_out   (pkt_if),
    .sync      (sync),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_err  = 1'b0;

  typedef struct {
    logic [63:0] cnt;
    logic [7:0]  gap;
    int          d;         // cycles after WAIT entry before sync rises
    bit          hold;      // keep next command pending on cmd_valid while busy
    int          abort_at;  // cycle at which reset is asserted (0 = never)
    int          exp_pkts;
    int          exp_done;  // done offset from accept cycle, -1 = none
    bit          exp_err;
  } vec_t;

  // {cmd_ready, busy, done, err, valid, addr, data}
  function automatic logic [76:0] observed();
    return {cmd_ready, busy, done, err, pkt_if.valid, pkt_if.addr, pkt_if.data};
  endfunction

  function automatic logic [76:0] expect_vec(bit r, bit b, bit dn, bit e, bit v,
                                             logic [7:0] a, logic [63:0] dt);
    return {r, b, dn, e, v, a, dt};
  endfunction

  task automatic checkOutput(input string name, input logic [76:0] act,
                             input logic [76:0] expv);
    n_checks++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [63:0] cnt,
                               input logic [7:0] gap, input bit s);
    cmd_valid = v;
    cmd_count = cnt;
    cmd_gap   = gap;
    sync      = s;
  endtask

  // Holds reset for n cycles checking all outputs low, releases it, checks
  // the first idle cycle, and returns at the start of the following cycle.
  task automatic do_reset(input int n);
    reset = 1'b1;
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0);
    repeat (n) begin
      @(negedge clk);
      checkOutput("reset_outputs", observed(), 77'd0);
      @(posedge clk);
      #1;
    end
    reset   = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_idle", observed(),
                expect_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 64'd0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      applyStimulus(1'b0, 64'd0, 8'd0, 1'($urandom_range(0, 1)));
      @(negedge clk);
      checkOutput("idle", observed(),
                  expect_vec(1'b1, 1'b0, 1'b0, exp_err, 1'b0, 8'd0, 64'd0));
      @(posedge clk);
      #1;
    end
  endtask

  // Runs one command starting at an idle cycle (cycle 0 = accept cycle).
  task automatic run_cmd(input logic [63:0] cnt, input logic [7:0] gap,
                         input int d, input bit hold,
                         input logic [63:0] hcnt, input logic [7:0] hgap,
                         input int abort_at,
                         output int pkts, output int done_off, output bit got_err);
    logic [71:0] entry;
    logic [71:0] done_k;
    logic [71:0] kk;
    int          k;
    int          dmin;
    bit          new_err;
    bit          ev;
    logic [7:0]  ea;
    logic [63:0] ed;
    bit          ee;

    // WAIT_SYNC entry: right after LOAD when count is 0, else right after
    // the last DEC, which sits (count-1)*(gap+1) cycles after the first.
    if (cnt == 64'd0) begin
      entry = 72'd2;
    end else begin
      entry = 72'd3 + (72'(cnt) - 72'd1) * (72'(gap) + 72'd1);
    end
    dmin    = (d < TMO - 1) ? d : TMO - 1;
    new_err = (d > TMO - 1);
    done_k  = entry + 72'(dmin) + 72'd1;

    pkts     = 0;
    done_off = -1;
    got_err  = 1'b0;
    k        = 0;
    applyStimulus(1'b1, cnt, gap, 1'($urandom_range(0, 1)));

    forever begin
      kk = 72'(k);
      ev = 1'b0;
      ea = 8'd0;
      ed = 64'd0;
      if (k == 1) begin
        ev = 1'b1;
        ea = 8'(LOAD_A);
        ed = cnt;
      end else if (k >= 2 && kk < entry && ((k - 2) % (int'(gap) + 1)) == 0) begin
        ev = 1'b1;
        ea = 8'(DEC_A);
      end
      if (k == 0) begin
        ee = exp_err;
      end else begin
        ee = (kk == done_k) ? new_err : 1'b0;
      end

      @(negedge clk);
      checkOutput($sformatf("cyc%0d", k), observed(),
                  expect_vec(k == 0, k != 0, kk == done_k, ee, ev, ea, ed));
      if (pkt_if.valid) begin
        pkts++;
      end
      if (done) begin
        done_off = k;
        got_err  = err;
      end
      if (kk >= done_k) begin
        break;
      end
      if (k >= MAX_CYC) begin
        checkInt("cycle_budget", k, -1);
        break;
      end

      @(posedge clk);
      #1;
      k++;

      if (abort_at != 0 && k == abort_at) begin
        do_reset(3);
        return;
      end

      if (72'(k) < entry) begin
        sync = 1'($urandom_range(0, 1));
      end else begin
        sync = (72'(k) >= entry + 72'(d));
      end

      if (hold) begin
        cmd_valid = 1'b1;
        cmd_count = hcnt;
        cmd_gap   = hgap;
      end else begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_count = {$urandom, $urandom};
        cmd_gap   = 8'($urandom);
      end
    end

    exp_err = new_err;
    @(posedge clk);
    #1;
    if (hold) begin
      applyStimulus(1'b1, hcnt, hgap, 1'b0);
    end else begin
      applyStimulus(1'b0, 64'd0, 8'd0, 1'b0);
    end
  endtask

  vec_t        vecs[10];
  vec_t        rnd[16];
  int          pkts;
  int          doff;
  bit          gerr;
  logic [63:0] ncnt;
  logic [7:0]  ngap;

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0);

    //          cnt                    gap  d    hold abort pkts done err
    vecs[0] = '{64'd3,                 8'd0, 1,   0,   0,    4,   7,   0};
    vecs[1] = '{64'd2,                 8'd4, 0,   0,   0,    3,   9,   0};
    vecs[2] = '{64'd0,                 8'd3, 0,   0,   0,    1,   3,   0};
    vecs[3] = '{64'd1,                 8'd0, 15,  0,   0,    2,   19,  0};
    vecs[4] = '{64'd1,                 8'd2, 16,  0,   0,    2,   19,  1};
    vecs[5] = '{64'd0,                 8'd0, 100, 1,   0,    1,   18,  1};
    vecs[6] = '{64'd4,                 8'd1, 3,   1,   0,    5,   13,  0};
    vecs[7] = '{64'd2,                 8'd0, 0,   0,   0,    3,   5,   0};
    vecs[8] = '{64'd10,                8'd3, 0,   0,   3,    2,   -1,  0};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 0, 0,   8,    7,   -1,  0};

    do_reset(3);
    idle_cycles(2);

    for (int i = 0; i < 10; i++) begin
      ncnt = (i < 9) ? vecs[i+1].cnt : 64'd0;
      ngap = (i < 9) ? vecs[i+1].gap : 8'd0;
      run_cmd(vecs[i].cnt, vecs[i].gap, vecs[i].d, vecs[i].hold, ncnt, ngap,
              vecs[i].abort_at, pkts, doff, gerr);
      checkInt($sformatf("vec%0d_pkts", i), pkts, vecs[i].exp_pkts);
      checkInt($sformatf("vec%0d_done", i), doff, vecs[i].exp_done);
      checkInt($sformatf("vec%0d_err", i), int'(gerr), int'(vecs[i].exp_err));
      if (vecs[i].abort_at != 0) begin
        idle_cycles(4);
      end
    end

    for (int i = 0; i < 16; i++) begin
      rnd[i].cnt  = 64'($urandom_range(0, 5));
      rnd[i].gap  = 8'($urandom_range(0, 4));
      rnd[i].d    = $urandom_range(0, 20);
      rnd[i].hold = (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      ncnt = (i < 15) ? rnd[i+1].cnt : 64'd0;
      ngap = (i < 15) ? rnd[i+1].gap : 8'd0;
      run_cmd(rnd[i].cnt, rnd[i].gap, rnd[i].d, rnd[i].hold, ncnt, ngap, 0,
              pkts, doff, gerr);
      checkInt($sformatf("rnd%0d_pkts", i), pkts, int'(rnd[i].cnt) + 1);
      if (!rnd[i].hold && ($urandom_range(0, 1) == 1)) begin
        idle_cycles(2);
      end
    end

    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
